// File: rtl/rvfi_mem_serializer_if.sv
// RVFI memory retirement bundle in, serialized access stream out.
// master drives retirements and out_ready; slave is the serializer.
interface rvfi_mem_serializer_if #(
  parameter int XLEN = 32,
  parameter int NRET = 2
);
  logic [NRET-1:0]        rvfi_valid;
  logic [64*NRET-1:0]     rvfi_order;
  logic [XLEN*NRET-1:0]   rvfi_mem_addr;
  logic [XLEN/8*NRET-1:0] rvfi_mem_rmask;
  logic [XLEN/8*NRET-1:0] rvfi_mem_wmask;
  logic [XLEN*NRET-1:0]   rvfi_mem_rdata;
  logic [XLEN*NRET-1:0]   rvfi_mem_wdata;

  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_order;
  logic [XLEN-1:0]   out_mem_addr;
  logic [XLEN/8-1:0] out_mem_rmask;
  logic [XLEN/8-1:0] out_mem_wmask;
  logic [XLEN-1:0]   out_mem_rdata;
  logic [XLEN-1:0]   out_mem_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_mem_addr,
    output rvfi_mem_rmask, rvfi_mem_wmask,
    output rvfi_mem_rdata, rvfi_mem_wdata,
    output out_ready,
    input  out_valid, out_order, out_mem_addr,
    input  out_mem_rmask, out_mem_wmask,
    input  out_mem_rdata, out_mem_wdata
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_mem_addr,
    input  rvfi_mem_rmask, rvfi_mem_wmask,
    input  rvfi_mem_rdata, rvfi_mem_wdata,
    input  out_ready,
    output out_valid, out_order, out_mem_addr,
    output out_mem_rmask, out_mem_wmask,
    output out_mem_rdata, out_mem_wdata
  );
endinterface

// File: rtl/rvfi_mem_serializer.sv
// NRET-wide RVFI memory retirements -> one-per-cycle FIFO stream.
// Optional checker macro: RVFI_MEM_SERIAL_ORDER_CHK_EN.
module rvfi_mem_serializer #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  rvfi_mem_serializer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
);
  localparam int MW = XLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] addr;
    logic [MW-1:0]   rmask;
    logic [MW-1:0]   wmask;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;
  } ent_t;

  typedef enum logic {
    S_EMPTY,
    S_NONEMPTY
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  ent_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_fill;
  logic          r_ovf;

  logic [NRET-1:0] w_q;
  logic [AW-1:0]   w_off [NRET];
  ent_t            w_in  [NRET];
  logic [CW-1:0]   w_n;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_add;
  logic [CW-1:0]   w_fill_nxt;
  logic            w_drop;
  logic            w_pop;

  // qualify channels and give each a slot offset in ascending order
  always_comb begin
    w_n = '0;
    for (int c = 0; c < NRET; c++) begin
      w_q[c] = bus.rvfi_valid[c] &&
        ((bus.rvfi_mem_rmask[c*MW +: MW] |
          bus.rvfi_mem_wmask[c*MW +: MW]) != '0);
      w_off[c] = w_n[AW-1:0];
      w_n = w_n + {{(CW-1){1'b0}}, w_q[c]};
      w_in[c] = '{
        order: bus.rvfi_order[c*64 +: 64],
        addr:  bus.rvfi_mem_addr[c*XLEN +: XLEN],
        rmask: bus.rvfi_mem_rmask[c*MW +: MW],
        wmask: bus.rvfi_mem_wmask[c*MW +: MW],
        rdata: bus.rvfi_mem_rdata[c*XLEN +: XLEN],
        wdata: bus.rvfi_mem_wdata[c*XLEN +: XLEN]
      };
    end
  end

  // all-or-nothing admission against pre-pop free space
  always_comb begin
    w_free     = CW'(DEPTH) - r_fill;
    w_drop     = (w_n > w_free);
    w_add      = w_drop ? '0 : w_n;
    w_pop      = bus.out_valid && bus.out_ready;
    w_fill_nxt = r_fill + w_add - {{(CW-1){1'b0}}, w_pop};
  end

  // next state: empty vs holding entries
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY:
        if (w_add != '0) w_state_nxt = S_NONEMPTY;
      S_NONEMPTY:
        if (w_fill_nxt == '0) w_state_nxt = S_EMPTY;
      default:
        w_state_nxt = S_EMPTY;
    endcase
  end

  // control state, pointers, count and sticky overflow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
      r_wr    <= '0;
      r_rd    <= '0;
      r_fill  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fill  <= w_fill_nxt;
      r_wr    <= r_wr + w_add[AW-1:0];
      if (w_pop)  r_rd  <= r_rd + AW'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // entry storage; admitted slots are always free
  always_ff @(posedge clock) begin
    for (int c = 0; c < NRET; c++) begin
      if (!w_drop && w_q[c])
        r_mem[r_wr + w_off[c]] <= w_in[c];
    end
  end

  assign bus.out_valid     = (r_state == S_NONEMPTY);
  assign bus.out_order     = r_mem[r_rd].order;
  assign bus.out_mem_addr  = r_mem[r_rd].addr;
  assign bus.out_mem_rmask = r_mem[r_rd].rmask;
  assign bus.out_mem_wmask = r_mem[r_rd].wmask;
  assign bus.out_mem_rdata = r_mem[r_rd].rdata;
  assign bus.out_mem_wdata = r_mem[r_rd].wdata;
  assign fill              = r_fill;
  assign overflow          = r_ovf;

`ifdef RVFI_MEM_SERIAL_ORDER_CHK_EN
  logic [63:0] r_last_order;
  logic        r_seen;

  // remember the last consumed order
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last_order <= '0;
      r_seen       <= 1'b0;
    end else if (w_pop) begin
      r_last_order <= bus.out_order;
      r_seen       <= 1'b1;
    end
  end

  // popped orders strictly rise; nothing is ever dropped
  always @(posedge clock) begin
    if (resetn) begin
      if (w_pop && r_seen)
        assert (bus.out_order > r_last_order)
          else $error("order not increasing");
      assert (!w_drop)
        else $error("memory events dropped");
    end
  end
`endif
endmodule
